// File: rtl/program_loader.sv
// Boot loader: takes a length-prefixed byte stream, writes it into program memory from address 0, then releases the CPU reset.
// Optional trailing checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int ADDR_WIDTH   = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int RESET_CYCLES = 5
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  in_ready_o,
  output logic [ADDR_WIDTH-1:0] mem_address_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  mem_write_o,
  output logic                  cpu_reset_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [2:0]            state_o
);

  // Handshake: a byte moves on a rising edge where in_valid_i & in_ready_o;
  // in_ready_o depends on the state register only, never on in_valid_i.

  localparam int CNT_W = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES + 1);
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM = 3'd3,
`endif
    S_HOLD = 3'd4,
    S_RUN  = 3'd5,
    S_ERR  = 3'd6
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   n_q, n_d;
  logic [ADDR_WIDTH:0]   idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic [DATA_WIDTH-1:0] csum_total;
  assign csum_total = sum_q + in_data_i;
`endif

  logic xfer;
  assign xfer = in_valid_i & in_ready_o;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      S_IDLE, S_RUN, S_ERR: begin
        if (start_i) state_d = S_LEN;
      end
      S_LEN: begin
        if (xfer) begin
          idx_d = '0;
`ifdef LOADER_CHECKSUM_EN
          sum_d = '0;
`endif
          // A length byte of zero means a full memory image.
          n_d = (in_data_i == '0) ? DEPTH : in_data_i[ADDR_WIDTH:0];
          if (in_data_i > DATA_WIDTH'(DEPTH)) state_d = S_ERR;
          else                                state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          wr_d   = 1'b1;
          addr_d = idx_q[ADDR_WIDTH-1:0];
          data_d = in_data_i;
          idx_d  = idx_q + (ADDR_WIDTH+1)'(1);
`ifdef LOADER_CHECKSUM_EN
          sum_d  = sum_q + in_data_i;
          if (idx_d == n_q) state_d = S_CSUM;
`else
          if (idx_d == n_q) begin
            state_d = S_HOLD;
            cnt_d   = CNT_W'(RESET_CYCLES);
          end
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (xfer) begin
          if (csum_total == '0) begin
            state_d = S_HOLD;
            cnt_d   = CNT_W'(RESET_CYCLES);
          end else begin
            state_d = S_ERR;
          end
        end
      end
`endif
      S_HOLD: begin
        if (cnt_q == '0) state_d = S_RUN;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = 1'b0;
    cpu_reset_o = 1'b1;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    error_o     = 1'b0;
    case (state_q)
      S_LEN, S_DATA: begin
        in_ready_o = 1'b1;
        busy_o     = 1'b1;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        in_ready_o = 1'b1;
        busy_o     = 1'b1;
      end
`endif
      S_HOLD: busy_o = 1'b1;
      S_RUN: begin
        cpu_reset_o = 1'b0;
        done_o      = 1'b1;
      end
      S_ERR:   error_o = 1'b1;
      default: ;
    endcase
  end

  assign mem_write_o   = wr_q;
  assign mem_address_o = addr_q;
  assign mem_data_o    = data_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader; follows LOADER_CHECKSUM_EN when it is defined for the build.
module tb_program_loader;
  localparam int RC = 5;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, start, in_valid;
  logic [7:0] in_data;
  logic       in_ready_o, mem_write_o, cpu_reset_o, busy_o, done_o, error_o;
  logic [3:0] mem_address_o;
  logic [7:0] mem_data_o;
  logic [2:0] state_o;

  program_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .RESET_CYCLES(RC)) dut (
    .clock_i(clk), .reset_i(rst), .start_i(start), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(in_ready_o), .mem_address_o(mem_address_o), .mem_data_o(mem_data_o),
    .mem_write_o(mem_write_o), .cpu_reset_o(cpu_reset_o), .busy_o(busy_o), .done_o(done_o),
    .error_o(error_o), .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // ---------------- monitor / scoreboard ----------------
  logic [11:0] wr_q[$];
  int          wcyc_q[$];
  logic [11:0] exp_q[$];
  int          acc_q[$];
  int          fall_edge = -1;
  int          last_acc = -1;
  logic        prev_cr;
  logic [7:0]  dat[16];
  int          gap[16];
  bit          ended;

  always @(negedge clk) begin
    if (mem_write_o === 1'b1) begin
      wr_q.push_back({mem_address_o, mem_data_o});
      wcyc_q.push_back(cyc);
    end
    if (prev_cr === 1'b1 && cpu_reset_o === 1'b0) fall_edge = cyc;
    prev_cr = cpu_reset_o;
  end

  // ---------------- drivers ----------------
  task automatic do_reset;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, output int acc_edge);
    in_valid = 1'b1; in_data = b; acc_edge = -1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (in_ready_o === 1'b1) begin
        @(posedge clk); #1;
        acc_edge = cyc;
        break;
      end
    end
    in_valid = 1'b0;
    if (acc_edge < 0) begin
      checks++; failures++;
      $display("FAIL send_byte_timeout got=in_ready_low exp=accept byte=%0h", b);
    end else begin
      last_acc = acc_edge;
    end
  endtask

  task automatic send_data(input int nb);
    int e;
    for (int i = 0; i < nb; i++) begin
      idle(gap[i]);
      send_byte(dat[i], e);
      acc_q.push_back(e);
    end
  endtask

  task automatic wait_end;
    ended = 1'b0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (done_o === 1'b1 || error_o === 1'b1) begin ended = 1'b1; break; end
    end
    @(posedge clk); #1;
    checks++;
    if (!ended) begin failures++; $display("FAIL wait_end got=no_done_no_error exp=terminal_state"); end
  endtask

  task automatic clear_sb;
    wr_q.delete(); wcyc_q.delete(); acc_q.delete(); exp_q.delete();
    fall_edge = -1;
    foreach (gap[i]) gap[i] = 0;
  endtask

  // ---------------- reference model ----------------
  // Outcome of one stream from the loader's rules: which writes happen and whether it ends in error.
  task automatic build_expect(input int l, input logic [7:0] cs, output bit exp_err);
    int n, sum;
    exp_q.delete();
    exp_err = 1'b0;
    if (l > 16) begin
      exp_err = 1'b1;
    end else begin
      n = (l == 0) ? 16 : l;
      sum = 0;
      for (int i = 0; i < n; i++) begin
        exp_q.push_back({4'(i), dat[i]});
        sum = sum + int'(dat[i]);
      end
      if (CSUM_EN && ((sum + int'(cs)) % 256) != 0) exp_err = 1'b1;
    end
  endtask

  function automatic logic [7:0] good_csum(input int n);
    int sum = 0;
    for (int i = 0; i < n; i++) sum = sum + int'(dat[i]);
    return 8'((256 - (sum % 256)) % 256);
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset;
    do_reset();
    checks++; if (cpu_reset_o !== 1'b1) begin failures++; $display("FAIL rst_cpu_reset got=%0b exp=1", cpu_reset_o); end
    checks++; if (in_ready_o !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%0b exp=0", in_ready_o); end
    checks++; if (mem_write_o !== 1'b0) begin failures++; $display("FAIL rst_mem_write got=%0b exp=0", mem_write_o); end
    checks++; if (mem_address_o !== 4'h0) begin failures++; $display("FAIL rst_mem_address got=%0h exp=0", mem_address_o); end
    checks++; if (mem_data_o !== 8'h00) begin failures++; $display("FAIL rst_mem_data got=%0h exp=0", mem_data_o); end
    checks++; if ({busy_o, done_o, error_o} !== 3'b000) begin failures++; $display("FAIL rst_status got=%0b exp=000", {busy_o, done_o, error_o}); end
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    checks++; if (busy_o !== 1'b0 || in_ready_o !== 1'b0) begin failures++; $display("FAIL rst_wins_over_start got=%0b exp=00", {busy_o, in_ready_o}); end
  endtask

  task automatic test_basic;
    bit ee;
    clear_sb();
    dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h33;
    build_expect(3, 8'h9A, ee);
    pulse_start();
    checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL basic_ready_after_start got=%0b exp=1", in_ready_o); end
    send_byte(8'd3, last_acc);
    send_data(3);
    if (CSUM_EN) send_byte(8'h9A, last_acc);
    wait_end();
    checks++; if (wr_q.size() !== 3) begin failures++; $display("FAIL basic_write_count got=%0d exp=3", wr_q.size()); end
    for (int i = 0; i < 3 && i < wr_q.size(); i++) begin
      checks++; if (wr_q[i] !== exp_q[i]) begin failures++; $display("FAIL basic_write%0d got=%0h exp=%0h", i, wr_q[i], exp_q[i]); end
      checks++; if (wcyc_q[i] !== acc_q[0] + i) begin failures++; $display("FAIL basic_write_cycle%0d got=%0d exp=%0d", i, wcyc_q[i], acc_q[0] + i); end
    end
    checks++; if (fall_edge !== last_acc + 1 + RC) begin failures++; $display("FAIL basic_release_edge got=%0d exp=%0d", fall_edge, last_acc + 1 + RC); end
    checks++; if (done_o !== 1'b1 || cpu_reset_o !== 1'b0) begin failures++; $display("FAIL basic_run got=%0b exp=10", {done_o, cpu_reset_o}); end
  endtask

  task automatic test_full16;
    bit ee;
    clear_sb();
    for (int i = 0; i < 16; i++) dat[i] = 8'(i);
    build_expect(0, good_csum(16), ee);
    pulse_start();
    checks++; if (cpu_reset_o !== 1'b1 || busy_o !== 1'b1 || done_o !== 1'b0) begin failures++; $display("FAIL full_restart_from_run got=%0b exp=110", {cpu_reset_o, busy_o, done_o}); end
    send_byte(8'd0, last_acc);
    send_data(16);
    if (CSUM_EN) send_byte(good_csum(16), last_acc);
    wait_end();
    idle(3);
    checks++; if (wr_q.size() !== 16) begin failures++; $display("FAIL full_write_count got=%0d exp=16", wr_q.size()); end
    for (int i = 0; i < 16 && i < wr_q.size(); i++) begin
      checks++; if (wr_q[i] !== exp_q[i]) begin failures++; $display("FAIL full_write%0d got=%0h exp=%0h", i, wr_q[i], exp_q[i]); end
    end
    checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL full_done got=%0b exp=1", done_o); end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_bad_csum;
    clear_sb();
    dat[0] = 8'h01; dat[1] = 8'h02;
    pulse_start();
    send_byte(8'd2, last_acc);
    send_data(2);
    send_byte(8'h00, last_acc);
    wait_end();
    idle(8);
    checks++; if (error_o !== 1'b1 || cpu_reset_o !== 1'b1) begin failures++; $display("FAIL badcs_error got=%0b exp=11", {error_o, cpu_reset_o}); end
    checks++; if (in_ready_o !== 1'b0 || fall_edge !== -1) begin failures++; $display("FAIL badcs_held got=%0b/%0d exp=0/-1", in_ready_o, fall_edge); end
    pulse_start();
    checks++; if (error_o !== 1'b0) begin failures++; $display("FAIL badcs_error_clears got=%0b exp=0", error_o); end
    dat[0] = 8'h5A;
    send_byte(8'd1, last_acc);
    send_data(1);
    send_byte(8'hA6, last_acc);
    wait_end();
    checks++; if (done_o !== 1'b1 || error_o !== 1'b0) begin failures++; $display("FAIL badcs_recover got=%0b exp=10", {done_o, error_o}); end
  endtask
`endif

  task automatic test_len_too_big;
    clear_sb();
    pulse_start();
    send_byte(8'h11, last_acc);
    checks++; if (error_o !== 1'b1 || busy_o !== 1'b0 || cpu_reset_o !== 1'b1) begin failures++; $display("FAIL biglen_err got=%0b exp=101", {error_o, busy_o, cpu_reset_o}); end
    idle(5);
    checks++; if (wr_q.size() !== 0 || in_ready_o !== 1'b0) begin failures++; $display("FAIL biglen_no_write got=%0d/%0b exp=0/0", wr_q.size(), in_ready_o); end
    dat[0] = 8'h40; dat[1] = 8'h80;
    pulse_start();
    checks++; if (error_o !== 1'b0) begin failures++; $display("FAIL biglen_error_clears got=%0b exp=0", error_o); end
    send_byte(8'd2, last_acc);
    send_data(2);
    if (CSUM_EN) send_byte(good_csum(2), last_acc);
    wait_end();
    checks++; if (done_o !== 1'b1 || wr_q.size() !== 2) begin failures++; $display("FAIL biglen_recover got=%0b/%0d exp=1/2", done_o, wr_q.size()); end
  endtask

  task automatic test_bubbles;
    bit ee;
    bit pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    int j = 0;
    clear_sb();
    for (int i = 0; i < 4; i++) dat[i] = 8'hA0 + 8'(i);
    build_expect(4, good_csum(4), ee);
    pulse_start();
    send_byte(8'd4, last_acc);
    for (int p = 0; p < 7; p++) begin
      in_valid = pat[p];
      in_data  = pat[p] ? dat[j] : 8'hEE;
      @(posedge clk); #1;
      if (pat[p]) begin acc_q.push_back(cyc); last_acc = cyc; j++; end
    end
    in_valid = 1'b0;
    if (CSUM_EN) send_byte(good_csum(4), last_acc);
    wait_end();
    checks++; if (wr_q.size() !== 4) begin failures++; $display("FAIL bub_write_count got=%0d exp=4", wr_q.size()); end
    for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
      checks++; if (wr_q[i] !== exp_q[i] || wcyc_q[i] !== acc_q[i]) begin failures++; $display("FAIL bub_write%0d got=%0h@%0d exp=%0h@%0d", i, wr_q[i], wcyc_q[i], exp_q[i], acc_q[i]); end
    end
    checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL bub_done got=%0b exp=1", done_o); end
  endtask

  task automatic test_reset_mid;
    clear_sb();
    for (int i = 0; i < 5; i++) dat[i] = 8'h70 + 8'(i);
    pulse_start();
    send_byte(8'd5, last_acc);
    send_data(2);
    in_valid = 1'b1; in_data = dat[2]; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (mem_write_o !== 1'b0 || mem_address_o !== 4'h0 || mem_data_o !== 8'h00) begin failures++; $display("FAIL midrst_mem got=%0b/%0h/%0h exp=0/0/0", mem_write_o, mem_address_o, mem_data_o); end
    checks++; if ({cpu_reset_o, in_ready_o, busy_o, done_o, error_o} !== 5'b10000) begin failures++; $display("FAIL midrst_status got=%0b exp=10000", {cpu_reset_o, in_ready_o, busy_o, done_o, error_o}); end
    idle(3);
    in_valid = 1'b0;
    checks++; if (wr_q.size() !== 2) begin failures++; $display("FAIL midrst_write_count got=%0d exp=2", wr_q.size()); end
  endtask

  task automatic test_random;
    bit ee;
    int l, n;
    logic [7:0] cs;
    for (int it = 0; it < 20; it++) begin
      clear_sb();
      l = ($urandom_range(0, 7) == 0) ? int'($urandom_range(17, 255)) : int'($urandom_range(0, 16));
      n = (l > 16) ? 0 : ((l == 0) ? 16 : l);
      for (int i = 0; i < 16; i++) begin
        dat[i] = 8'($urandom_range(0, 255));
        gap[i] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 2)) : 0;
      end
      cs = good_csum(n);
      if (CSUM_EN && $urandom_range(0, 3) == 0) cs = cs + 8'($urandom_range(1, 255));
      build_expect(l, cs, ee);
      pulse_start();
      send_byte(8'(l), last_acc);
      if (l <= 16) begin
        send_data(n);
        if (CSUM_EN) send_byte(cs, last_acc);
      end
      wait_end();
      checks++; if (wr_q.size() !== exp_q.size()) begin failures++; $display("FAIL rnd%0d_write_count got=%0d exp=%0d", it, wr_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
        checks++; if (wr_q[i] !== exp_q[i]) begin failures++; $display("FAIL rnd%0d_write%0d got=%0h exp=%0h", it, i, wr_q[i], exp_q[i]); end
      end
      checks++; if ({error_o, done_o, cpu_reset_o} !== {ee, !ee, ee}) begin failures++; $display("FAIL rnd%0d_outcome got=%0b exp=%0b", it, {error_o, done_o, cpu_reset_o}, {ee, !ee, ee}); end
      if (!ee) begin
        checks++; if (fall_edge !== last_acc + 1 + RC) begin failures++; $display("FAIL rnd%0d_release_edge got=%0d exp=%0d", it, fall_edge, last_acc + 1 + RC); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full16();
`ifdef LOADER_CHECKSUM_EN
    test_bad_csum();
`endif
    test_len_too_big();
    test_bubbles();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
